// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one external asynchronous SRAM between the instruction-fetch port
//   and the data (load/store) port. Every access runs as a
//   SETUP / STROBE (WAIT_CYCLES) / HOLD sequence with active-low strobes.
//   The data port normally wins a simultaneous contest. After STARVE_LIMIT
//   consecutive losses, fetch wins the next one.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request (level) and address
//   if_rdata/if_ack       : fetch read data, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata : data request, write flag, address, write data
//   d_rdata/d_ack         : data read data, one-cycle completion pulse
//   sram_addr/sram_dout   : SRAM address pins, value for the data bus
//   sram_drive            : enables the top-level tristate driver
//   sram_din              : sampled SRAM data bus
//   sram_en_n/oe_n/we_n   : active-low chip, output and write enables
//   busy                  : high whenever an access is in progress
module sram_port_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [17:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [17:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dout,
  output logic        sram_drive,
  input  logic [15:0] sram_din,
  output logic        sram_en_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} stateT;

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  stateT      state;
  logic       grantData;  // arbitration result, meaningful in IDLE only
  logic       latData;    // granted port: 1 = data, 0 = fetch
  logic       latWe;      // granted access is a write
  logic [3:0] waitCnt;
  logic [3:0] starveCnt;

  always_comb begin
    grantData = d_req && !(if_req && (starveCnt >= STARVE_MAX));
  end

  assign busy = (state != IDLE);

  // The latched address and write data live directly in sram_addr and
  // sram_dout. They are held across IDLE, so no separate copy is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      latData    <= 1'b0;
      latWe      <= 1'b0;
      waitCnt    <= '0;
      starveCnt  <= '0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_drive <= 1'b0;
      sram_en_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_req || d_req) begin
            latData   <= grantData;
            latWe     <= grantData && d_we;
            sram_addr <= grantData ? d_addr : if_addr;
            sram_en_n <= 1'b0;
            if (grantData && d_we) begin
              sram_dout  <= d_wdata;
              sram_drive <= 1'b1;
            end
            if (!grantData) begin
              starveCnt <= '0;
            end else if (if_req && (starveCnt != 4'd15)) begin
              starveCnt <= starveCnt + 4'd1;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (latWe) begin
            sram_we_n <= 1'b0;
          end else begin
            sram_oe_n <= 1'b0;
          end
          waitCnt <= WAIT_LOAD;
          state   <= STROBE;
        end
        STROBE: begin
          if (waitCnt == 4'd0) begin
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (!latWe) begin
              if (latData) begin
                d_rdata <= sram_din;
              end else begin
                if_rdata <= sram_din;
              end
            end
            if (latData) begin
              d_ack <= 1'b1;
            end else begin
              if_ack <= 1'b1;
            end
            state <= HOLD;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        HOLD: begin
          sram_en_n  <= 1'b1;
          sram_drive <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Self-checking bench for sram_port_arbiter. A transaction-level model
//   tracks each grant and the number of cycles since it. From that it works
//   out the expected pins cycle by cycle. Directed scenarios come first,
//   followed by a randomized phase with handshake-respecting requesters.
module tb_sram_port_arbiter;

  localparam int W = 2;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifReq = 1'b0;
  logic [17:0] ifAddr = '0;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        dReq = 1'b0;
  logic        dWe = 1'b0;
  logic [17:0] dAddr = '0;
  logic [15:0] dWdata = '0;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic [17:0] sram_addr;
  logic [15:0] sram_dout;
  logic        sram_drive;
  logic [15:0] sramDin = '0;
  logic        sram_en_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        busy;

  sram_port_arbiter #(
    .WAIT_CYCLES (W),
    .STARVE_LIMIT(L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (ifReq),
    .if_addr   (ifAddr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (dReq),
    .d_we      (dWe),
    .d_addr    (dAddr),
    .d_wdata   (dWdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout),
    .sram_drive(sram_drive),
    .sram_din  (sramDin),
    .sram_en_n (sram_en_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transaction-level model
  int          cyc = 0;
  bit          mActive = 0;
  int          mGrant = 0;
  bit          mPortD = 0;
  bit          mWe = 0;
  logic [17:0] mAddr = '0;
  logic [15:0] mDout = '0;
  logic [15:0] mIfR = '0;
  logic [15:0] mDR = '0;
  int          mStarve = 0;
  bit          mD;
  int          mOff;
  bit eBusy = 0, eEn = 1, eOe = 1, eWe = 1, eDrive = 0, eIfAck = 0, eDAck = 0;
  bit grantLog[$];
  int grantCyc[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mActive = 0; mAddr = '0; mDout = '0; mIfR = '0; mDR = '0; mStarve = 0;
    end else if (mActive) begin
      mOff = cyc - mGrant;
      if (mOff == W + 1 && !mWe) begin
        if (mPortD) mDR = sramDin; else mIfR = sramDin;
      end
      if (mOff == W + 2) mActive = 0;
    end else if (ifReq || dReq) begin
      mD = dReq && !(ifReq && mStarve >= L);
      if (!mD) mStarve = 0;
      else if (ifReq) mStarve = (mStarve < 15) ? mStarve + 1 : 15;
      mActive = 1; mGrant = cyc; mPortD = mD; mWe = mD && dWe;
      mAddr = mD ? dAddr : ifAddr;
      if (mWe) mDout = dWdata;
      grantLog.push_back(mD);
      grantCyc.push_back(cyc);
    end
    mOff   = cyc - mGrant;
    eBusy  = mActive;
    eEn    = !mActive;
    eDrive = mActive && mWe;
    eOe    = !(mActive && !mWe && mOff >= 1 && mOff <= W);
    eWe    = !(mActive && mWe && mOff >= 1 && mOff <= W);
    eIfAck = mActive && mOff == W + 1 && !mPortD;
    eDAck  = mActive && mOff == W + 1 && mPortD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison plus pin activity counters for the directed tests
  bit checkEn = 1;
  int oeLowCnt = 0, weLowCnt = 0, driveCnt = 0, ifAckCnt = 0, dAckCnt = 0;
  int lastIfAckCyc = 0;

  always @(negedge clk) begin
    if (checkEn) begin
      chk("busy", busy, eBusy);
      chk("en_n", sram_en_n, eEn);
      chk("oe_n", sram_oe_n, eOe);
      chk("we_n", sram_we_n, eWe);
      chk("drive", sram_drive, eDrive);
      chk("addr", sram_addr, mAddr);
      if (eDrive) chk("dout", sram_dout, mDout);
      chk("if_ack", if_ack, eIfAck);
      chk("d_ack", d_ack, eDAck);
      chk("if_rdata", if_rdata, mIfR);
      chk("d_rdata", d_rdata, mDR);
      chk("oneAck", if_ack & d_ack, 0);
      chk("oeWeOverlap", !sram_oe_n && !sram_we_n, 0);
    end
    if (sram_oe_n === 1'b0) oeLowCnt++;
    if (sram_we_n === 1'b0) weLowCnt++;
    if (sram_drive === 1'b1) driveCnt++;
    if (if_ack === 1'b1) begin ifAckCnt++; lastIfAckCyc = cyc; end
    if (d_ack === 1'b1) dAckCnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearStats();
    oeLowCnt = 0; weLowCnt = 0; driveCnt = 0; ifAckCnt = 0; dAckCnt = 0;
    grantLog.delete();
    grantCyc.delete();
  endtask

  task automatic waitAck(input bit isD);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if ((isD ? d_ack : if_ack) === 1'b1) ok = 1;
    end
    chk(isD ? "dAckTimeout" : "ifAckTimeout", ok, 1);
  endtask

  task automatic waitAnyAck(output bit gotD);
    bit ok;
    ok = 0;
    gotD = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (d_ack === 1'b1) begin ok = 1; gotD = 1; end
      else if (if_ack === 1'b1) ok = 1;
    end
    chk("anyAckTimeout", ok, 1);
  endtask

  task automatic doReset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  bit expPat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    bit gotD;
    // Reset state
    doReset();
    chk("rstBusy", busy, 0);
    chk("rstStrobes", {sram_en_n, sram_oe_n, sram_we_n}, 3'b111);

    // Single fetch read
    clearStats();
    sramDin = 16'h1234;
    ifReq = 1; ifAddr = 18'h00010;
    waitAck(0);
    ifReq = 0;
    tick(); tick();
    chk("t1_rdata", if_rdata, 16'h1234);
    chk("t1_oeLow", oeLowCnt, 2);
    chk("t1_ifAcks", ifAckCnt, 1);
    chk("t1_grants", grantLog.size(), 1);
    if (grantCyc.size() == 1) chk("t1_latency", lastIfAckCyc - grantCyc[0], W + 1);

    // Data write
    clearStats();
    dReq = 1; dWe = 1; dAddr = 18'h3FFFF; dWdata = 16'hBEEF;
    waitAck(1);
    dReq = 0; dWe = 0;
    tick(); tick();
    chk("t2_weLow", weLowCnt, 2);
    chk("t2_oeLow", oeLowCnt, 0);
    chk("t2_drive", driveCnt, W + 2);
    chk("t2_dAcks", dAckCnt, 1);
    chk("t2_rdata", d_rdata, 16'h0000);

    // Simultaneous held requests: starvation pattern
    doReset();
    clearStats();
    ifReq = 1; dReq = 1; ifAddr = 18'h100; dAddr = 18'h200;
    for (int i = 0; i < 10; i++) begin
      waitAnyAck(gotD);
      if (gotD) dAddr = dAddr + 18'd1; else ifAddr = ifAddr + 18'd1;
    end
    ifReq = 0; dReq = 0;
    tick(); tick(); tick();
    chk("t3_count", grantLog.size(), 10);
    for (int i = 0; i < 10 && i < grantLog.size(); i++) chk("t3_order", grantLog[i], expPat[i]);
    chk("t3_acks", ifAckCnt + dAckCnt, 10);

    // Back-to-back fetch with req held
    clearStats();
    ifReq = 1; ifAddr = 18'h00A0;
    for (int i = 0; i < 3; i++) begin
      waitAck(0);
      ifAddr = ifAddr + 18'h10;
    end
    ifReq = 0;
    tick(); tick();
    chk("t4_count", grantCyc.size(), 3);
    if (grantCyc.size() == 3) begin
      chk("t4_gap1", grantCyc[1] - grantCyc[0], W + 3);
      chk("t4_gap2", grantCyc[2] - grantCyc[1], W + 3);
    end

    // Reset during STROBE of a write, then a normal read
    clearStats();
    dReq = 1; dWe = 1; dAddr = 18'h00155; dWdata = 16'h0F0F;
    tick(); tick(); tick();
    rst = 1; dReq = 0; dWe = 0;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_strobes", {sram_en_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("t5_drive", sram_drive, 0);
    chk("t5_ack", d_ack, 0);
    rst = 0;
    sramDin = 16'hA5A5;
    dReq = 1; dAddr = 18'h00020;
    waitAck(1);
    dReq = 0;
    tick();
    chk("t5_rdata", d_rdata, 16'hA5A5);

    // Data request withdrawn while fetch is strobing
    tick(); tick();
    clearStats();
    ifReq = 1; ifAddr = 18'h00030;
    tick(); tick();
    dReq = 1; dAddr = 18'h00040;
    tick();
    dReq = 0;
    waitAck(0);
    ifReq = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_dAcks", dAckCnt, 0);
    chk("t6_grants", grantLog.size(), 1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      sramDin = 16'($urandom);
      rst = ($urandom_range(199) == 0);
      if (ifReq) begin
        if (if_ack === 1'b1) begin
          if ($urandom_range(1) == 0) ifReq = 0; else ifAddr = 18'($urandom);
        end else if (!(mActive && !mPortD) && $urandom_range(7) == 0) begin
          ifReq = 0;
        end
      end else if ($urandom_range(2) == 0) begin
        ifReq = 1; ifAddr = 18'($urandom);
      end
      if (dReq) begin
        if (d_ack === 1'b1) begin
          if ($urandom_range(1) == 0) dReq = 0;
          else begin dAddr = 18'($urandom); dWe = 1'($urandom); dWdata = 16'($urandom); end
        end else if (!(mActive && mPortD) && $urandom_range(7) == 0) begin
          dReq = 0;
        end
      end else if ($urandom_range(2) == 0) begin
        dReq = 1; dAddr = 18'($urandom); dWe = 1'($urandom); dWdata = 16'($urandom);
      end
      tick();
    end
    rst = 0; ifReq = 0; dReq = 0;
    for (int i = 0; i < 10; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
